// File: rtl/dc_tagcheck_rrip.sv
// dc_tagcheck_rrip -- set-associative L1 data-cache tag check and
// replacement controller with RRIP victim selection.
//
// One core load/store is looked up at a time against the tag, coherence
// state (I/S/M) and RRPV held in flops for every way of the addressed set.
// On a miss (or a store to an S line) the block asks L2 for the line, waits
// for the snoop-ack, picks a victim with SRRIP, displaces it if valid and
// fills the new tag.
//
// Optional feature: define DC_TAGCHECK_BRRIP_EN for bimodal insertion
// (a 5-bit fill counter chooses RRPV_MAX-1 on one fill in 32, RRPV_MAX
// otherwise). Undefined: every non-upgrade fill inserts RRPV_MAX-1.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_retry    core request handshake (store, index, tag)
//   resp_valid/resp_retry  lookup result handshake (hit, way)
//   l1tol2_req_*           L2 request channel (REQ_S / REQ_M)
//   l2tol1_snack_*         L2 snoop-ack input (ACK_S / ACK_M accepted)
//   l1tol2_disp_*          displacement channel (code, evicted tag)
// A beat transfers on a rising edge with valid=1 and retry=0.

`ifndef SC_CMD_REQ_S
`define SC_CMD_REQ_S 3'b001
`endif
`ifndef SC_CMD_REQ_M
`define SC_CMD_REQ_M 3'b010
`endif
`ifndef SC_SCMD_ACK_S
`define SC_SCMD_ACK_S 5'b00001
`endif
`ifndef SC_SCMD_ACK_M
`define SC_SCMD_ACK_M 5'b00010
`endif

module dc_tagcheck_rrip #(
  parameter int WAYS      = 8,
  parameter int SETS      = 32,
  parameter int IDX_BITS  = 5,
  parameter int TAG_BITS  = 10,
  parameter int RRPV_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_retry,
  input  logic                        req_store,
  input  logic [IDX_BITS-1:0]         req_index,
  input  logic [TAG_BITS-1:0]         req_tag,
  output logic                        resp_valid,
  input  logic                        resp_retry,
  output logic                        resp_hit,
  output logic [$clog2(WAYS)-1:0]     resp_way,
  output logic                        l1tol2_req_valid,
  input  logic                        l1tol2_req_retry,
  output logic [2:0]                  l1tol2_req,
  input  logic                        l2tol1_snack_valid,
  input  logic [4:0]                  l2tol1_snack,
  output logic                        l1tol2_disp_valid,
  input  logic                        l1tol2_disp_retry,
  output logic [2:0]                  l1tol2_disp,
  output logic [TAG_BITS-1:0]         l1tol2_disp_tag
);

  localparam int WAY_BITS = $clog2(WAYS);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOOKUP   = 3'd1;
  localparam logic [2:0] RESP     = 3'd2;
  localparam logic [2:0] MISS_REQ = 3'd3;
  localparam logic [2:0] WAIT_ACK = 3'd4;
  localparam logic [2:0] VICTIM   = 3'd5;
  localparam logic [2:0] DISP     = 3'd6;
  localparam logic [2:0] FILL     = 3'd7;

  localparam logic [1:0] LS_I = 2'd0;
  localparam logic [1:0] LS_S = 2'd1;
  localparam logic [1:0] LS_M = 2'd2;

  localparam logic [RRPV_BITS-1:0] RRPV_MAX  = '1;
  localparam logic [RRPV_BITS-1:0] RRPV_NEAR = RRPV_MAX - 1'b1;

  logic [2:0]           st;
  logic [TAG_BITS-1:0]  tag_mem  [SETS][WAYS];
  logic [1:0]           lst      [SETS][WAYS];
  logic [RRPV_BITS-1:0] rrpv     [SETS][WAYS];

  logic                 store_r;
  logic [IDX_BITS-1:0]  idx_r;
  logic [TAG_BITS-1:0]  tag_r;
  logic [WAY_BITS-1:0]  way_r;
  logic                 hit_r;
  logic                 upg_r;
  logic                 ackm_r;

  logic                 hit_found, hit_m;
  logic [WAY_BITS-1:0]  hit_way;
  logic                 inv_found, max_found;
  logic [WAY_BITS-1:0]  inv_way, max_way;
  logic                 ack_ok;
  logic                 lookup_hit;
  logic [RRPV_BITS-1:0] ins_rrpv;

  // Scan downward so the lowest-index candidate is the one left standing.
  always_comb begin
    hit_found = 1'b0;
    hit_m     = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    max_found = 1'b0;
    max_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (lst[idx_r][i] != LS_I && tag_mem[idx_r][i] == tag_r) begin
        hit_found = 1'b1;
        hit_m     = (lst[idx_r][i] == LS_M);
        hit_way   = WAY_BITS'(i);
      end
      if (lst[idx_r][i] == LS_I) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(i);
      end
      if (rrpv[idx_r][i] == RRPV_MAX) begin
        max_found = 1'b1;
        max_way   = WAY_BITS'(i);
      end
    end
  end

  // A store that finds the line only in S still needs ownership from L2.
  assign lookup_hit = hit_found && (!store_r || hit_m);
  assign ack_ok     = l2tol1_snack_valid &&
                      (l2tol1_snack == `SC_SCMD_ACK_S || l2tol1_snack == `SC_SCMD_ACK_M);

`ifdef DC_TAGCHECK_BRRIP_EN
  logic [4:0] fill_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
    end else if (st == FILL && !upg_r) begin
      fill_cnt <= fill_cnt + 5'd1;
    end
  end

  assign ins_rrpv = (fill_cnt == 5'd0) ? RRPV_NEAR : RRPV_MAX;
`else
  assign ins_rrpv = RRPV_NEAR;
`endif

  // Control: FSM plus per-line coherence state and RRPV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          lst[s][w]  <= LS_I;
          rrpv[s][w] <= RRPV_MAX;
        end
      end
    end else begin
      case (st)
        IDLE:     if (req_valid) st <= LOOKUP;
        LOOKUP: begin
          if (lookup_hit) begin
            rrpv[idx_r][hit_way] <= '0;
            st <= RESP;
          end else begin
            st <= MISS_REQ;
          end
        end
        RESP:     if (!resp_retry) st <= IDLE;
        MISS_REQ: if (!l1tol2_req_retry) st <= WAIT_ACK;
        WAIT_ACK: if (ack_ok) st <= upg_r ? FILL : VICTIM;
        VICTIM: begin
          if (inv_found) begin
            st <= FILL;
          end else if (max_found) begin
            st <= DISP;
          end else begin
            // No way at RRPV_MAX yet: age the whole set and look again.
            for (int w = 0; w < WAYS; w++) begin
              if (rrpv[idx_r][w] != RRPV_MAX) rrpv[idx_r][w] <= rrpv[idx_r][w] + 1'b1;
            end
          end
        end
        DISP: begin
          if (!l1tol2_disp_retry) begin
            lst[idx_r][way_r] <= LS_I;
            st <= FILL;
          end
        end
        FILL: begin
          lst[idx_r][way_r]  <= ackm_r ? LS_M : LS_S;
          rrpv[idx_r][way_r] <= upg_r ? '0 : ins_rrpv;
          st <= RESP;
        end
        default:  st <= IDLE;
      endcase
    end
  end

  // Datapath: captured request, selected way and tag array.
  always_ff @(posedge clk) begin
    case (st)
      IDLE: begin
        if (req_valid) begin
          store_r <= req_store;
          idx_r   <= req_index;
          tag_r   <= req_tag;
        end
      end
      LOOKUP: begin
        hit_r <= lookup_hit;
        upg_r <= hit_found && store_r && !hit_m;
        way_r <= hit_way;
      end
      WAIT_ACK: if (ack_ok) ackm_r <= (l2tol1_snack == `SC_SCMD_ACK_M);
      VICTIM: begin
        if (inv_found)      way_r <= inv_way;
        else if (max_found) way_r <= max_way;
      end
      FILL:     tag_mem[idx_r][way_r] <= tag_r;
      default: ;
    endcase
  end

  // Payloads are forced to zero whenever their valid is low.
  assign req_retry         = reset || (st != IDLE);
  assign resp_valid        = (st == RESP);
  assign resp_hit          = (st == RESP) && hit_r;
  assign resp_way          = (st == RESP) ? way_r : '0;
  assign l1tol2_req_valid  = (st == MISS_REQ);
  assign l1tol2_req        = (st != MISS_REQ) ? 3'b000 :
                             (store_r ? `SC_CMD_REQ_M : `SC_CMD_REQ_S);
  assign l1tol2_disp_valid = (st == DISP);
  assign l1tol2_disp       = (st != DISP) ? 3'b000 :
                             ((lst[idx_r][way_r] == LS_M) ? 3'b010 : 3'b001);
  assign l1tol2_disp_tag   = (st == DISP) ? tag_mem[idx_r][way_r] : '0;

endmodule
